// File: rtl/sub_pkg.sv
// Shared defaults and FSM encoding for the sub-window accumulator.
package sub_pkg;
  localparam int DEF_DIFF_W = 5;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_ACC_W  = DEF_DIFF_W + DEF_CNT_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/sub_win_minmax.sv
// Running signed min/max of the current window. The outputs already include
// this cycle's sample when en is high, so the parent can register a final
// result on the completing cycle.
module sub_win_minmax #(
  parameter int W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] sample,
  input  logic                first,
  input  logic                en,
  output logic signed [W-1:0] win_min,
  output logic signed [W-1:0] win_max
);
  logic signed [W-1:0] min_q, max_q;

  // The first sample of a window seeds both extremes; later samples compare.
  always_comb begin
    win_min = min_q;
    win_max = max_q;
    if (en) begin
      if (first) begin
        win_min = sample;
        win_max = sample;
      end else begin
        win_min = (sample < min_q) ? sample : min_q;
        win_max = (sample > max_q) ? sample : max_q;
      end
    end
  end

  // Hold the running extremes between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (en) begin
      min_q <= win_min;
      max_q <= win_max;
    end
  end
endmodule

// File: rtl/sub_window_acc.sv
// Accumulates N signed difference samples into one window result with
// sum/min/max, presented on a valid/ready port. Accumulation never stalls:
// a result that completes while the previous one is still unaccepted is
// dropped and flagged on the sticky ovfErr.
module sub_window_acc
  import sub_pkg::*;
#(
  parameter int DIFF_W = DEF_DIFF_W,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int ACC_W = DIFF_W + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIFF_W-1:0] diffIn,
  input  logic                     diffValid,
  input  logic        [CNT_W-1:0]  winLen,
  output logic signed [ACC_W-1:0]  sumOut,
  output logic signed [DIFF_W-1:0] minOut,
  output logic signed [DIFF_W-1:0] maxOut,
  output logic                     sumValid,
  input  logic                     sumReady,
  output logic                     ovfErr,
  input  logic                     clrErr
);
  // One extra bit so a window of 2^CNT_W samples is representable.
  localparam int CW = CNT_W + 1;

  state_t                    state, state_nxt;
  logic        [CW-1:0]      cnt, cnt_nxt, n_len, n_nxt, n_in;
  logic signed [ACC_W-1:0]   acc, acc_nxt, diff_ext;
  logic signed [DIFF_W-1:0]  cur_min, cur_max;
  logic                      first, done;

  assign first    = (state == IDLE);
  assign diff_ext = $signed({{CNT_W{diffIn[DIFF_W-1]}}, diffIn});
  assign n_in     = (winLen == '0) ? CW'(1 << CNT_W) : {1'b0, winLen};

  sub_win_minmax #(.W(DIFF_W)) u_minmax (
    .clk     (clk),
    .rst     (rst),
    .sample  (diffIn),
    .first   (first),
    .en      (diffValid),
    .win_min (cur_min),
    .win_max (cur_max)
  );

  // Next-state, running sum/count and window-completion detect.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n_len;
    acc_nxt   = acc;
    done      = 1'b0;
    if (diffValid) begin
      if (state == IDLE) begin
        acc_nxt = diff_ext;
        cnt_nxt = CW'(1);
        n_nxt   = n_in;
        if (n_in == CW'(1)) done = 1'b1;
        else                state_nxt = ACCUM;
      end else begin
        acc_nxt = acc + diff_ext;
        cnt_nxt = cnt + CW'(1);
        if (cnt_nxt == n_len) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      n_len <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n_len <= n_nxt;
      acc   <= acc_nxt;
    end
  end

  // Result register with hold-until-accepted and drop-on-overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumOut   <= '0;
      minOut   <= '0;
      maxOut   <= '0;
      sumValid <= 1'b0;
    end else if (done && (!sumValid || sumReady)) begin
      sumOut   <= acc_nxt;
      minOut   <= cur_min;
      maxOut   <= cur_max;
      sumValid <= 1'b1;
    end else if (sumValid && sumReady) begin
      sumValid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ovfErr <= 1'b0;
    else if (done && sumValid && !sumReady) ovfErr <= 1'b1;
    else if (clrErr)                        ovfErr <= 1'b0;
  end
endmodule
